// File: rtl/seq_divider4_pkg.sv
// Shared definitions for the sequential restoring divider: default width,
// FSM state encoding and counter sizing.
package seq_divider4_pkg;

  localparam int DIV_WIDTH = 4;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] CALC = 1'b1;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider4_subtractor.sv
// N-bit combinational ripple-borrow subtractor (diff = a - b - bin) built from
// chained full-subtractor cells.
module ripple_subtractor #(
  parameter int N = 5
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout
);

  logic [N:0] brw;

  assign brw[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_cell
    assign diff[i]  = a[i] ^ b[i] ^ brw[i];
    assign brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
  end

  assign bout = brw[N];

endmodule

// File: rtl/seq_divider4.sv
// Sequential unsigned restoring divider: one shift/trial-subtract step per
// clock, WIDTH steps per division, start/busy/done handshake.
module seq_divider4
  import seq_divider4_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  logic [0:0]       state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] d_reg;

  logic [WIDTH:0]   t;
  logic [WIDTH:0]   diff;
  logic             borrow;
  logic             fits;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH-1:0] r_next;
  logic             accept;

  assign accept = start & ~busy;

  // Trial subtraction of the divisor from the shifted partial remainder
  assign t = {r_reg, q_reg[WIDTH-1]};

  ripple_subtractor #(.N(WIDTH + 1)) u_sub (
    .a    (t),
    .b    ({1'b0, d_reg}),
    .bin  (1'b0),
    .diff (diff),
    .bout (borrow)
  );

  // With R < D the difference never reaches bit WIDTH, so this only hardens the test
  assign fits   = ~borrow & ~diff[WIDTH];
  assign r_next = fits ? diff[WIDTH-1:0] : t[WIDTH-1:0];
  assign q_next = {q_reg[WIDTH-2:0], fits};

  // Working registers: only meaningful while CALC, so they need no reset
  always_ff @(posedge clk) begin
    if (accept) begin
      q_reg <= dividend;
      d_reg <= divisor;
      r_reg <= '0;
    end else if (state == CALC) begin
      q_reg <= q_next;
      r_reg <= r_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        if (divisor == '0) begin
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
          done        <= 1'b1;
        end else begin
          state <= CALC;
          count <= CNT_W'(WIDTH);
          busy  <= 1'b1;
        end
      end else if (state == CALC) begin
        count <= count - 1'b1;
        if (count == CNT_W'(1)) begin
          quotient    <= q_next;
          remainder   <= r_next;
          div_by_zero <= 1'b0;
          done        <= 1'b1;
          busy        <= 1'b0;
          state       <= IDLE;
        end
      end
    end
  end

endmodule
